// File: rtl/mesh_terminal_nic_if.sv
// Host/router-facing signal bundle of the mesh terminal NIC.
// The NIC takes the slave modport. The host/router side takes the master modport.
interface mesh_terminal_nic_if #(
  parameter int unsigned pckg_sz = 40
);
  logic [pckg_sz-1:0] tx_data;
  logic               tx_push;
  logic               tx_full;
  logic [pckg_sz-1:0] data_out_i_in;
  logic               pndng_i_in;
  logic               popin;
  logic [pckg_sz-1:0] data_out;
  logic               pndng;
  logic               pop;
  logic [pckg_sz-1:0] rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic               rx_misroute;
  logic [15:0]        tx_cnt;
  logic [15:0]        rx_cnt;
  logic [15:0]        err_cnt;

  modport slave (
    input  tx_data, tx_push, popin, data_out, pndng, rx_ready,
    output tx_full, data_out_i_in, pndng_i_in, pop, rx_data, rx_valid,
           rx_misroute, tx_cnt, rx_cnt, err_cnt
  );

  modport master (
    output tx_data, tx_push, popin, data_out, pndng, rx_ready,
    input  tx_full, data_out_i_in, pndng_i_in, pop, rx_data, rx_valid,
           rx_misroute, tx_cnt, rx_cnt, err_cnt
  );
endinterface

// File: rtl/mesh_terminal_nic.sv
// Terminal NIC for one mesh_gnrtr port: TX FIFO toward router ingress,
// one-entry RX holding register from router egress, misroute check and counters.
module mesh_terminal_nic #(
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4,
  parameter int unsigned ROWS       = 4,
  parameter int unsigned COLUMS     = 4,
  parameter logic [3:0]  MY_ROW     = 4'd0,
  parameter logic [3:0]  MY_COL     = 4'd1,
  parameter logic [7:0]  bdcst      = 8'hFF
) (
  input logic                clk,
  input logic                reset,
  mesh_terminal_nic_if.slave bus
);
  localparam int unsigned AW = (fifo_depth > 1) ? $clog2(fifo_depth) : 1;
  localparam int unsigned CW = $clog2(fifo_depth + 1);
  localparam logic [7:0]  MY_ID = {MY_ROW, MY_COL};

  if (pckg_sz < 20 || fifo_depth < 2 || 32'(MY_ROW) >= ROWS || 32'(MY_COL) >= COLUMS) begin : g_bad_cfg
    $error("mesh_terminal_nic: illegal parameter combination");
  end

  typedef enum logic {RX_EMPTY = 1'b0, RX_HOLD = 1'b1} rx_state_t;

  logic [pckg_sz-1:0] r_mem [fifo_depth];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [15:0]        r_tx_cnt;

  rx_state_t          r_rx_state;
  logic [pckg_sz-1:0] r_rx_data;
  logic               r_rx_misroute;
  logic [15:0]        r_rx_cnt;
  logic [15:0]        r_err_cnt;

  logic               w_full;
  logic               w_empty;
  logic               w_tx_pop;
  logic               w_tx_push;
  logic               w_rx_pop;
  logic [7:0]         w_dest;
  logic               w_misroute;

  function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
    return (p == AW'(fifo_depth - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_full    = (r_count == CW'(fifo_depth));
  assign w_empty   = (r_count == '0);
  assign w_tx_pop  = bus.popin && !w_empty;
  // A push while full succeeds only when the head leaves in the same cycle.
  assign w_tx_push = bus.tx_push && (!w_full || w_tx_pop);

  // TX FIFO and sent-packet counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < fifo_depth; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) begin
        r_mem[r_wr_ptr] <= {8'h00, bus.tx_data[pckg_sz-9:0]};
        r_wr_ptr        <= f_inc(r_wr_ptr);
      end
      if (w_tx_pop) begin
        r_rd_ptr <= f_inc(r_rd_ptr);
        if (r_tx_cnt != 16'hFFFF) r_tx_cnt <= r_tx_cnt + 16'd1;
      end
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.tx_full       = w_full;
  assign bus.pndng_i_in    = !w_empty;
  assign bus.data_out_i_in = w_empty ? '0 : r_mem[r_rd_ptr];
  assign bus.tx_cnt        = r_tx_cnt;

  assign w_dest     = bus.data_out[pckg_sz-9 -: 8];
  assign w_misroute = (w_dest != MY_ID) && (w_dest != bdcst);
  // Reset forces the egress dequeue low at once so nothing is lost mid-reset.
  assign w_rx_pop   = !reset && bus.pndng && ((r_rx_state == RX_EMPTY) || bus.rx_ready);

  // RX holding register FSM with capture-time misroute check
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_state    <= RX_EMPTY;
      r_rx_data     <= '0;
      r_rx_misroute <= 1'b0;
      r_rx_cnt      <= '0;
      r_err_cnt     <= '0;
    end else begin
      if (w_rx_pop) begin
        r_rx_state    <= RX_HOLD;
        r_rx_data     <= bus.data_out;
        r_rx_misroute <= w_misroute;
        if (r_rx_cnt != 16'hFFFF) r_rx_cnt <= r_rx_cnt + 16'd1;
        if (w_misroute && (r_err_cnt != 16'hFFFF)) r_err_cnt <= r_err_cnt + 16'd1;
      end else if ((r_rx_state == RX_HOLD) && bus.rx_ready) begin
        r_rx_state <= RX_EMPTY;
      end
    end
  end

  assign bus.pop         = w_rx_pop;
  assign bus.rx_data     = r_rx_data;
  assign bus.rx_valid    = (r_rx_state == RX_HOLD);
  assign bus.rx_misroute = r_rx_misroute;
  assign bus.rx_cnt      = r_rx_cnt;
  assign bus.err_cnt     = r_err_cnt;
endmodule

// File: tb/tb_mesh_terminal_nic.sv
// Directed bench for mesh_terminal_nic: TX FIFO, RX handshake, misroute, reset.
module tb_mesh_terminal_nic;
  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  mesh_terminal_nic_if #(.pckg_sz(40)) bus ();

  mesh_terminal_nic #(
    .pckg_sz(40), .fifo_depth(4), .ROWS(4), .COLUMS(4),
    .MY_ROW(4'd0), .MY_COL(4'd1), .bdcst(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.tx_data = '0; bus.tx_push = 1'b0; bus.popin = 1'b0;
    bus.data_out = '0; bus.pndng = 1'b0; bus.rx_ready = 1'b0;
    tick(); tick();
    n_checks++; if (bus.pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL reset_pndng_i_in got %b exp 0", bus.pndng_i_in); end
    n_checks++; if (bus.tx_full !== 1'b0) begin n_fail++; $display("FAIL reset_tx_full got %b exp 0", bus.tx_full); end
    n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid got %b exp 0", bus.rx_valid); end
    n_checks++; if (bus.rx_misroute !== 1'b0) begin n_fail++; $display("FAIL reset_rx_misroute got %b exp 0", bus.rx_misroute); end
    n_checks++; if (bus.data_out_i_in !== 40'h0) begin n_fail++; $display("FAIL reset_data_out_i_in got %h exp 0", bus.data_out_i_in); end
    n_checks++; if (bus.rx_data !== 40'h0) begin n_fail++; $display("FAIL reset_rx_data got %h exp 0", bus.rx_data); end
    n_checks++; if ({bus.tx_cnt, bus.rx_cnt, bus.err_cnt} !== 48'h0) begin n_fail++; $display("FAIL reset_counters got %h exp 0", {bus.tx_cnt, bus.rx_cnt, bus.err_cnt}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_tx_single(input logic [15:0] exp_cnt);
    bus.tx_data = 40'hAB231ABCDE; bus.tx_push = 1'b1;
    tick();
    bus.tx_push = 1'b0;
    n_checks++; if (bus.pndng_i_in !== 1'b1) begin n_fail++; $display("FAIL tx1_pndng got %b exp 1", bus.pndng_i_in); end
    n_checks++; if (bus.data_out_i_in !== 40'h00231ABCDE) begin n_fail++; $display("FAIL tx1_head got %h exp 00231abcde", bus.data_out_i_in); end
    bus.popin = 1'b1;
    tick();
    bus.popin = 1'b0;
    n_checks++; if (bus.pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL tx1_pndng_after_pop got %b exp 0", bus.pndng_i_in); end
    n_checks++; if (bus.tx_cnt !== exp_cnt) begin n_fail++; $display("FAIL tx1_tx_cnt got %0d exp %0d", bus.tx_cnt, exp_cnt); end
    n_checks++; if (bus.data_out_i_in !== 40'h0) begin n_fail++; $display("FAIL tx1_head_empty got %h exp 0", bus.data_out_i_in); end
  endtask

  task automatic test_tx_full();
    logic [39:0] exp;
    for (int i = 0; i < 5; i++) begin
      bus.tx_data = 40'hFF01000000 + 40'(i); bus.tx_push = 1'b1;
      tick();
      n_checks++; if (bus.tx_full !== (i >= 3)) begin n_fail++; $display("FAIL full_flag push%0d got %b exp %b", i, bus.tx_full, (i >= 3)); end
    end
    bus.tx_push = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp = 40'h0001000000 + 40'(i);
      n_checks++; if (bus.data_out_i_in !== exp) begin n_fail++; $display("FAIL full_order%0d got %h exp %h", i, bus.data_out_i_in, exp); end
      bus.popin = 1'b1;
      tick();
    end
    bus.popin = 1'b0;
    n_checks++; if (bus.pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL full_drained got %b exp 0", bus.pndng_i_in); end
    n_checks++; if (bus.tx_cnt !== 16'd5) begin n_fail++; $display("FAIL full_tx_cnt got %0d exp 5", bus.tx_cnt); end
    // refill, then push and pop together while full
    for (int i = 0; i < 4; i++) begin
      bus.tx_data = 40'hEE220A0000 + 40'(i); bus.tx_push = 1'b1;
      tick();
    end
    bus.tx_data = 40'hEE220A0004; bus.popin = 1'b1;
    tick();
    bus.tx_push = 1'b0;
    n_checks++; if (bus.tx_full !== 1'b1) begin n_fail++; $display("FAIL simul_full got %b exp 1", bus.tx_full); end
    for (int i = 1; i < 5; i++) begin
      exp = 40'h00220A0000 + 40'(i);
      n_checks++; if (bus.data_out_i_in !== exp) begin n_fail++; $display("FAIL simul_order%0d got %h exp %h", i, bus.data_out_i_in, exp); end
      tick();
    end
    bus.popin = 1'b0;
    n_checks++; if (bus.tx_cnt !== 16'd10) begin n_fail++; $display("FAIL simul_tx_cnt got %0d exp 10", bus.tx_cnt); end
    n_checks++; if (bus.pndng_i_in !== 1'b0) begin n_fail++; $display("FAIL simul_empty got %b exp 0", bus.pndng_i_in); end
  endtask

  task automatic test_rx_back_to_back();
    logic [39:0] pkt;
    bus.rx_ready = 1'b1; bus.pndng = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pkt = 40'h5501000000 + 40'(k + 1);
      bus.data_out = pkt;
      #1;
      n_checks++; if (bus.pop !== 1'b1) begin n_fail++; $display("FAIL b2b_pop%0d got %b exp 1", k, bus.pop); end
      tick();
      n_checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== pkt) begin n_fail++; $display("FAIL b2b_data%0d got %b/%h exp 1/%h", k, bus.rx_valid, bus.rx_data, pkt); end
      n_checks++; if (bus.rx_misroute !== 1'b0) begin n_fail++; $display("FAIL b2b_misroute%0d got %b exp 0", k, bus.rx_misroute); end
    end
    bus.pndng = 1'b0;
    #1;
    n_checks++; if (bus.pop !== 1'b0) begin n_fail++; $display("FAIL b2b_pop_idle got %b exp 0", bus.pop); end
    tick();
    n_checks++; if (bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain got %b exp 0", bus.rx_valid); end
    n_checks++; if (bus.rx_cnt !== 16'd3 || bus.err_cnt !== 16'd0) begin n_fail++; $display("FAIL b2b_cnts got %0d/%0d exp 3/0", bus.rx_cnt, bus.err_cnt); end
  endtask

  task automatic test_misroute();
    bus.rx_ready = 1'b1; bus.pndng = 1'b1; bus.data_out = 40'h0022012345;
    tick();
    n_checks++; if (bus.rx_valid !== 1'b1 || bus.rx_data !== 40'h0022012345) begin n_fail++; $display("FAIL mis_deliver got %b/%h exp 1/0022012345", bus.rx_valid, bus.rx_data); end
    n_checks++; if (bus.rx_misroute !== 1'b1) begin n_fail++; $display("FAIL mis_flag got %b exp 1", bus.rx_misroute); end
    n_checks++; if (bus.err_cnt !== 16'd1) begin n_fail++; $display("FAIL mis_err_cnt got %0d exp 1", bus.err_cnt); end
    bus.data_out = 40'h00FF100000;
    tick();
    n_checks++; if (bus.rx_misroute !== 1'b0) begin n_fail++; $display("FAIL bcast_flag got %b exp 0", bus.rx_misroute); end
    n_checks++; if (bus.err_cnt !== 16'd1 || bus.rx_cnt !== 16'd5) begin n_fail++; $display("FAIL bcast_cnts got %0d/%0d exp 1/5", bus.err_cnt, bus.rx_cnt); end
    bus.pndng = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    bus.rx_ready = 1'b0; bus.pndng = 1'b1; bus.data_out = 40'h0001000AAA;
    #1;
    n_checks++; if (bus.pop !== 1'b1) begin n_fail++; $display("FAIL bp_first_pop got %b exp 1", bus.pop); end
    tick();
    bus.data_out = 40'h0001000BBB;
    for (int c = 0; c < 10; c++) begin
      n_checks++; if (bus.pop !== 1'b0 || bus.rx_data !== 40'h0001000AAA || bus.rx_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold%0d got pop %b data %h valid %b exp 0/0001000aaa/1", c, bus.pop, bus.rx_data, bus.rx_valid); end
      tick();
    end
    bus.rx_ready = 1'b1;
    #1;
    n_checks++; if (bus.pop !== 1'b1) begin n_fail++; $display("FAIL bp_release_pop got %b exp 1", bus.pop); end
    tick();
    n_checks++; if (bus.rx_data !== 40'h0001000BBB || bus.rx_cnt !== 16'd7) begin n_fail++; $display("FAIL bp_next got %h/%0d exp 0001000bbb/7", bus.rx_data, bus.rx_cnt); end
    bus.pndng = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      bus.tx_data = 40'h1133000000 + 40'(i); bus.tx_push = 1'b1;
      tick();
    end
    bus.tx_push = 1'b0;
    bus.rx_ready = 1'b0; bus.pndng = 1'b1; bus.data_out = 40'h0001000CCC;
    tick();
    n_checks++; if (bus.rx_valid !== 1'b1 || bus.pndng_i_in !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre got %b/%b exp 1/1", bus.rx_valid, bus.pndng_i_in); end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (bus.pndng_i_in !== 1'b0 || bus.rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags got %b/%b exp 0/0", bus.pndng_i_in, bus.rx_valid); end
    n_checks++; if (bus.pop !== 1'b0) begin n_fail++; $display("FAIL rstmid_pop got %b exp 0", bus.pop); end
    n_checks++; if ({bus.tx_cnt, bus.rx_cnt, bus.err_cnt} !== 48'h0) begin n_fail++; $display("FAIL rstmid_counters got %h exp 0", {bus.tx_cnt, bus.rx_cnt, bus.err_cnt}); end
    n_checks++; if (bus.data_out_i_in !== 40'h0 || bus.rx_data !== 40'h0) begin n_fail++; $display("FAIL rstmid_data got %h/%h exp 0/0", bus.data_out_i_in, bus.rx_data); end
    bus.pndng = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    test_tx_single(16'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_tx_single(16'd1);
    test_tx_full();
    test_rx_back_to_back();
    test_misroute();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
